// File: rtl/charlieplex_pkg.sv
// Shared constants and scan-state type for the charlieplexed 12x12 LED scanner.
package charlieplex_pkg;

    localparam int NUM_PINS   = 13;
    localparam int NUM_ROWS   = 12;
    localparam int NUM_COLS   = 12;
    localparam int FRAME_BITS = 144;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic int cp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/charlieplex_row_decode.sv
// Combinational map from (row, row cell bits) to charlieplex pin enables and levels.
module charlieplex_row_decode
    import charlieplex_pkg::*;
(
    input  logic [3:0]          row,
    input  logic [NUM_COLS-1:0] bits,
    output logic [NUM_PINS-1:0] oe,
    output logic [NUM_PINS-1:0] out
);

    logic [NUM_PINS-1:0] anode_s;
    logic [NUM_PINS-1:0] low_mask_s;
    logic [NUM_PINS-1:0] cathode_s;

    // Columns below the anode keep their pin index; columns at or above it shift up by one.
    assign anode_s    = 13'd1 << row;
    assign low_mask_s = anode_s - 13'd1;
    assign cathode_s  = ({1'b0, bits} & low_mask_s)
                      | ({bits, 1'b0} & ~low_mask_s & ~anode_s);

    assign oe  = anode_s | cathode_s;
    assign out = anode_s;

endmodule

// File: rtl/charlieplex_scanner.sv
// Double-buffered row scanner for a 13-pin charlieplexed 12x12 LED array with blanking gaps.
// Optional feature macro: CHARLIEPLEX_BRIGHTNESS_EN (adds a 4-bit per-row duty control).
module charlieplex_scanner
    import charlieplex_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
)
(
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  frame_valid,
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  frame_ready,
    output logic [NUM_PINS-1:0]   pin_oe,
    output logic [NUM_PINS-1:0]   pin_out,
    output logic [3:0]            row,
    output logic                  frame_start
);

    localparam int CW = $clog2(cp_max(DWELL_CYCLES, BLANK_CYCLES)) + 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t           state_r;
    logic [3:0]            row_r;
    logic [CW-1:0]         dcnt_r;
    logic [NUM_PINS-1:0]   pin_oe_r;
    logic [NUM_PINS-1:0]   pin_out_r;
    logic                  frame_start_r;
    logic                  frame_ready_r;
    logic [FRAME_BITS-1:0] shadow_r;
    logic [FRAME_BITS-1:0] active_r;

    logic [7:0]            base_s;
    logic [NUM_COLS-1:0]   row_bits_s;
    logic [NUM_PINS-1:0]   dec_oe_s;
    logic [NUM_PINS-1:0]   dec_out_s;
    logic                  wrap_s;

    assign base_s     = {4'd0, row_r} * 8'd12;
    assign row_bits_s = active_r[base_s +: NUM_COLS];
    assign wrap_s     = (state_r == DRIVE) && (dcnt_r == DWELL_LAST) && (row_r == 4'd11);

    charlieplex_row_decode u_decode (
        .row  (row_r),
        .bits (row_bits_s),
        .oe   (dec_oe_s),
        .out  (dec_out_s)
    );

`ifdef CHARLIEPLEX_BRIGHTNESS_EN
    localparam int PW = CW + 5;
    logic [3:0]    bright_r;
    logic [PW-1:0] lit_lhs_s;
    logic [PW-1:0] lit_rhs_s;
    logic          lit_s;

    // Duty test is evaluated for the dwell cycle about to be entered.
    assign lit_lhs_s = PW'(dcnt_r + CW'(1)) << 4;
    assign lit_rhs_s = PW'({1'b0, bright_r} + 5'd1) * PW'(DWELL_CYCLES);
    assign lit_s     = lit_lhs_s < lit_rhs_s;
`endif

    // Frame buffers: accept into shadow, promote to active only at the 11->0 wrap.
    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            shadow_r      <= {FRAME_BITS{1'b0}};
            active_r      <= {FRAME_BITS{1'b0}};
            frame_ready_r <= 1'b1;
        end else if (wrap_s && !frame_ready_r) begin
            active_r      <= shadow_r;
            frame_ready_r <= 1'b1;
        end else if (frame_valid && frame_ready_r) begin
            shadow_r      <= frame;
            frame_ready_r <= 1'b0;
        end else begin
            frame_ready_r <= frame_ready_r;
        end
    end

    // Scan FSM; pin outputs are registered from the state being entered.
    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            state_r       <= BLANK;
            row_r         <= 4'd0;
            dcnt_r        <= '0;
            pin_oe_r      <= '0;
            pin_out_r     <= '0;
            frame_start_r <= 1'b0;
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
            bright_r      <= 4'd15;
`endif
        end else begin
            case (state_r)
                BLANK: begin
                    if (dcnt_r == BLANK_LAST) begin
                        state_r       <= DRIVE;
                        dcnt_r        <= '0;
                        pin_oe_r      <= dec_oe_s;
                        pin_out_r     <= dec_out_s;
                        frame_start_r <= (row_r == 4'd0);
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
                        bright_r      <= brightness;
`endif
                    end else begin
                        dcnt_r        <= dcnt_r + CW'(1);
                        pin_oe_r      <= '0;
                        pin_out_r     <= '0;
                        frame_start_r <= 1'b0;
                    end
                end
                DRIVE: begin
                    frame_start_r <= 1'b0;
                    if (dcnt_r == DWELL_LAST) begin
                        state_r   <= BLANK;
                        dcnt_r    <= '0;
                        pin_oe_r  <= '0;
                        pin_out_r <= '0;
                        row_r     <= (row_r == 4'd11) ? 4'd0 : row_r + 4'd1;
                    end else begin
                        dcnt_r <= dcnt_r + CW'(1);
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
                        if (!lit_s) begin
                            pin_oe_r  <= '0;
                            pin_out_r <= '0;
                        end else begin
                            pin_oe_r  <= pin_oe_r;
                            pin_out_r <= pin_out_r;
                        end
`endif
                    end
                end
                default: begin
                    state_r       <= BLANK;
                    dcnt_r        <= '0;
                    pin_oe_r      <= '0;
                    pin_out_r     <= '0;
                    frame_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign frame_ready = frame_ready_r;
    assign pin_oe      = pin_oe_r;
    assign pin_out     = pin_out_r;
    assign row         = row_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Scoreboard bench: a cycle-position reference model predicts every output, a monitor compares.
module tb_charlieplex_scanner;

    localparam int DW  = 4;
    localparam int BW  = 2;
    localparam int RP  = DW + BW;
    localparam int FP  = 12 * RP;

    typedef struct packed {
        logic [12:0] oe;
        logic [12:0] out;
        logic [3:0]  row;
        logic        fs;
        logic        rdy;
    } exp_t;

    logic         clock;
    logic         aclr_n;
    logic [143:0] frame;
    logic         frame_valid;
    logic         frame_ready;
    logic [12:0]  pin_oe;
    logic [12:0]  pin_out;
    logic [3:0]   row;
    logic         frame_start;
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
    logic [3:0]   brightness = 4'd15;
`endif

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pos      = 0;
    logic [143:0] m_active = '0;
    logic [143:0] m_shadow = '0;
    logic         m_full   = 1'b0;

    charlieplex_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BW)) dut (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .frame       (frame),
        .frame_valid (frame_valid),
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .frame_ready (frame_ready),
        .pin_oe      (pin_oe),
        .pin_out     (pin_out),
        .row         (row),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t predict(input int p, input logic [143:0] img, input logic full);
        exp_t e;
        int r, ph, cp;
        e = '0;
        r  = (p / RP) % 12;
        ph = p % RP;
        e.row = 4'(r);
        e.rdy = !full;
        if (ph >= BW) begin
            e.oe[r]  = 1'b1;
            e.out[r] = 1'b1;
            e.fs     = (ph == BW) && (r == 0);
            for (int j = 0; j < 12; j++) begin
                if (img[r*12 + j]) begin
                    cp = (j < r) ? j : j + 1;
                    e.oe[cp] = 1'b1;
                end
            end
        end
        return e;
    endfunction

    // Reference model: schedule position since reset decides row/phase; buffers follow the handshake rules.
    initial begin
        forever begin
            @(posedge clock);
            if (!aclr_n) begin
                pos      = 0;
                m_active = '0;
                m_full   = 1'b0;
            end else begin
                if (((pos + 1) % FP) == 0 && m_full) begin
                    m_active = m_shadow;
                    m_full   = 1'b0;
                end else if (frame_valid && !m_full) begin
                    m_shadow = frame;
                    m_full   = 1'b1;
                end
                pos = pos + 1;
            end
            q.push_back(predict(pos, m_active, m_full));
        end
    end

    // Monitor: compares the DUT's registered outputs with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pin_oe",      32'(pin_oe),      32'(e.oe));
                chk("pin_out",     32'(pin_out),     32'(e.out));
                chk("row",         32'(row),         32'(e.row));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
                chk("frame_ready", 32'(frame_ready), 32'(e.rdy));
            end
        end
    end

    function automatic logic [143:0] rand_frame();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[143:0];
    endfunction

    task automatic send(input logic [143:0] f);
        bit acc;
        acc = 1'b0;
        frame       = f;
        frame_valid = 1'b1;
        for (int i = 0; i < 2 * FP + 10 && !acc; i++) begin
            acc = frame_ready;
            @(negedge clock);
        end
        frame_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept, required accept within %0d cycles", 2 * FP + 10);
        end
    endtask

    task automatic single_bit(input int b);
        logic [143:0] f;
        f = '0;
        f[b] = 1'b1;
        send(f);
    endtask

    initial begin
        bit hit;
        aclr_n      = 1'b0;
        frame_valid = 1'b0;
        frame       = '0;
        repeat (3) @(negedge clock);
        aclr_n = 1'b1;
        repeat (20) @(negedge clock);

        single_bit(0);
        single_bit(13);
        single_bit(143);
        send(rand_frame());
        send(rand_frame());
        repeat (2 * FP) @(negedge clock);

        hit = 1'b0;
        for (int i = 0; i < 2 * FP && !hit; i++) begin
            if ((pos % FP) == 5 * RP + BW + 1) hit = 1'b1;
            else @(negedge clock);
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL mid_drive_wait: got no row-5 drive slot, required one within %0d cycles", 2 * FP);
        end
        aclr_n = 1'b0;
        @(negedge clock);
        aclr_n = 1'b1;
        repeat (FP + 4) @(negedge clock);

        for (int i = 0; i < 900; i++) begin
            frame_valid = ($urandom_range(0, 3) == 0);
            frame       = rand_frame();
            aclr_n      = ($urandom_range(0, 399) != 0);
            @(negedge clock);
        end
        aclr_n      = 1'b1;
        frame_valid = 1'b0;
        repeat (FP + 4) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
